set_multi_circle: RTL and testbench
===================================

// Module: set_multi_circle
// PURPOSE
//  Parametrised successor of the 3-circle SET counter: counts grid points (x,y in 1..GRID)
//  covered by a set expression over NUM_C circles. Scans one grid row per cycle and
//  accumulates the count. Top-level compute block, driven by en/busy/valid handshake.
//  Adds circle mask, at-least-K and parity modes, and generic grid/circle count.
// PARAMETERS
//  NUM_C    3  number of circles (1..8)
//  COORD_W  4  width of each centre coordinate and radius (unsigned)
//  GRID     8  grid edge length; points 1..GRID on each axis, GRID <= 2**COORD_W-1
//  CNT_W    $clog2(GRID*GRID+1)  candidate width (derived localparam, not overridable)
//  K_W      $clog2(NUM_C+1)      threshold width (derived localparam)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous reset, active-low
//  en         in   1              start request, sampled only when busy=0
//  central    in   NUM_C*2*COORD_W  circle i: {x,y} at [i*2*COORD_W +: 2*COORD_W], x upper
//  radius     in   NUM_C*COORD_W  circle i radius at [i*COORD_W +: COORD_W]
//  circ_mask  in   NUM_C          1 = circle participates in expression
//  mode       in   3              set operation select (see BEHAVIOUR)
//  k_thresh   in   K_W            threshold for mode 4
//  busy       out  1              job in progress
//  valid      out  1              one-cycle result strobe
//  candidate  out  CNT_W          covered-point count, held until next accepted en
// BEHAVIOUR
//  - Reset (rst=0, async): busy=0, valid=0, candidate=0, FSM=IDLE, row counter=1, acc=0.
//  - FSM IDLE->SCAN on en&&!busy at edge T: latch central/radius/circ_mask/mode/k_thresh.
//    SCAN rows y=1..GRID over cycles T+1..T+GRID; stage-2 register popcounts row hits and
//    adds to acc; DONE in cycle T+GRID+2: valid=1, busy=0, candidate=acc; then IDLE.
//  - busy=1 in cycles T+1..T+GRID+1. Latency en->valid = GRID+2 cycles (10 at default).
//  - en while busy=1 ignored; inputs may change freely after acceptance edge.
//  - en in the valid cycle is accepted (busy=0): new job starts, candidate held until its valid.
//  - Membership: hit_i = mask_i && (x-cx)^2+(y-cy)^2 <= r^2; diffs signed COORD_W+1 bits,
//    squares/sum 2*COORD_W+3 bits, no overflow; off-grid centres legal.
//  - c = popcount(hit over masked circles), m = popcount(circ_mask).
//  - mode 0: hit_0 | 1: intersection, c==m && m!=0 | 2: union, c>=1 | 3: exactly one, c==1
//    mode 4: c>=k_thresh (k_thresh=0 -> every point, GRID*GRID) | 5: odd parity of c
//    modes 6,7: reserved, candidate=0 (full scan still runs, same latency).
//  - circ_mask=0: modes 1,2,3,5 give 0; mode 0 gives 0 (hit_0 gated by mask).
//  - Max count GRID*GRID fits CNT_W exactly; acc never wraps.
//  - Reset mid-scan: abort, no valid pulse, outputs to reset values; next en runs cleanly.
// CONFIGURATION
//  SET_HITMAP_EN defined: extra outputs row_valid(1), row_y(COORD_W), row_hits(GRID); in
//   stage-2 cycle of each row, row_valid=1, row_y=y, row_hits[x-1]=point selected by mode.
//   All reset to 0; row_valid low outside SCAN pipeline. GRID row strobes per job.
//  SET_HITMAP_EN undefined: ports absent; candidate/busy/valid timing identical.
// TESTING (GRID=8, NUM_C=3, COORD_W=4)
//  1 rst=0 mid-idle -> busy=0, valid=0, candidate=0 immediately (async).
//  2 A=(4,4) r=2, mask=001, mode 0, en at T -> valid only at T+10, candidate=13, busy T+1..T+9.
//  3 A=(3,3) r=2, B=(5,3) r=2, mask=011: mode 1 -> 5; mode 2 -> 21; mode 3 -> 16.
//  4 A=(4,4) r=15, mask=001, mode 0 -> 64; A as test 2 plus B=(1,1) r=0, mask=011,
//    mode 4 k=2 -> 0; mode 4 k=0 -> 64; mode 6 -> 0.
//  5 en pulsed at T+3 during busy -> ignored, single valid at T+10; en in valid cycle -> next
//    valid at T+20.
//  6 rst low at T+4 then en at T+7 (test 2 inputs) -> no valid before T+17, candidate=13;
//    with SET_HITMAP_EN: 8 row strobes, row_y=4 row_hits=8'b0011_1110.

Source files
------------

// File: rtl/set_multi_circle_if.sv
// rtl/set_multi_circle_if.sv - start/busy/valid job bus for the multi-circle SET counter (optional SET_HITMAP_EN row taps)
interface set_multi_circle_if #(
  parameter int NUM_C   = 3,
  parameter int COORD_W = 4,
  parameter int GRID    = 8
);
  localparam int CNT_W = $clog2(GRID*GRID+1);
  localparam int K_W   = $clog2(NUM_C+1);

  logic                     en;
  logic [NUM_C*2*COORD_W-1:0] central;
  logic [NUM_C*COORD_W-1:0] radius;
  logic [NUM_C-1:0]         circ_mask;
  logic [2:0]               mode;
  logic [K_W-1:0]           k_thresh;
  logic                     busy;
  logic                     valid;
  logic [CNT_W-1:0]         candidate;
`ifdef SET_HITMAP_EN
  logic                     row_valid;
  logic [COORD_W-1:0]       row_y;
  logic [GRID-1:0]          row_hits;
`endif

  modport master (
    output en, central, radius, circ_mask, mode, k_thresh,
`ifdef SET_HITMAP_EN
    input  row_valid, row_y, row_hits,
`endif
    input  busy, valid, candidate
  );

  modport slave (
    input  en, central, radius, circ_mask, mode, k_thresh,
`ifdef SET_HITMAP_EN
    output row_valid, row_y, row_hits,
`endif
    output busy, valid, candidate
  );
endinterface

// File: rtl/set_multi_circle.sv
// rtl/set_multi_circle.sv - row-per-cycle grid point counter over a masked set expression of NUM_C circles (optional SET_HITMAP_EN)
module set_multi_circle #(
  parameter int NUM_C   = 3,
  parameter int COORD_W = 4,
  parameter int GRID    = 8
) (
  input logic             clk,
  input logic             rst,
  set_multi_circle_if.slave bus
);
  localparam int CNT_W = $clog2(GRID*GRID+1);
  localparam int K_W   = $clog2(NUM_C+1);
  // Squared distances of up to (2**COORD_W-1) per axis, summed, never overflow this width.
  localparam int S_W   = 2*COORD_W+3;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t                     state;
  logic [COORD_W-1:0]         y_q;
  logic [NUM_C*2*COORD_W-1:0] cen_q;
  logic [NUM_C*COORD_W-1:0]   rad_q;
  logic [NUM_C-1:0]           mask_q;
  logic [2:0]                 mode_q;
  logic [K_W-1:0]             k_q;
  logic                       s2_valid;
  logic [CNT_W-1:0]           s2_cnt;
  logic [CNT_W-1:0]           acc;
  logic [CNT_W-1:0]           candidate_q;
  logic                       busy_q;
  logic                       valid_q;
`ifdef SET_HITMAP_EN
  logic [COORD_W-1:0]         s2_y;
  logic [GRID-1:0]            s2_hits;
`endif

  logic [COORD_W-1:0] xv, cx_v, cy_v, r_v;
  logic [S_W-1:0]     dx_e, dy_e, dsq, rsq;
  logic [K_W-1:0]     c_v, m_v;
  logic               hit_v, hit0_v, sel_v;
  logic [GRID-1:0]    row_sel;
  logic [CNT_W-1:0]   row_pop;

  // Evaluate every point of the current row against all circles and apply the selected set operation.
  always_comb begin
    xv      = '0;
    cx_v    = '0;
    cy_v    = '0;
    r_v     = '0;
    dx_e    = '0;
    dy_e    = '0;
    dsq     = '0;
    rsq     = '0;
    c_v     = '0;
    m_v     = '0;
    hit_v   = 1'b0;
    hit0_v  = 1'b0;
    sel_v   = 1'b0;
    row_sel = '0;
    row_pop = '0;
    for (int i = 0; i < NUM_C; i++) begin
      m_v = m_v + K_W'(mask_q[i]);
    end
    for (int x = 1; x <= GRID; x++) begin
      xv     = COORD_W'(x);
      c_v    = '0;
      hit0_v = 1'b0;
      for (int i = 0; i < NUM_C; i++) begin
        cx_v = cen_q[i*2*COORD_W+COORD_W +: COORD_W];
        cy_v = cen_q[i*2*COORD_W +: COORD_W];
        r_v  = rad_q[i*COORD_W +: COORD_W];
        // Modular subtraction yields the two's-complement difference; its square is exact in S_W bits.
        dx_e = S_W'(xv) - S_W'(cx_v);
        dy_e = S_W'(y_q) - S_W'(cy_v);
        dsq  = dx_e*dx_e + dy_e*dy_e;
        rsq  = S_W'(r_v) * S_W'(r_v);
        hit_v = mask_q[i] && (dsq <= rsq);
        c_v  = c_v + K_W'(hit_v);
        if (i == 0) hit0_v = hit_v;
      end
      case (mode_q)
        3'd0:    sel_v = hit0_v;
        3'd1:    sel_v = (c_v == m_v) && (m_v != '0);
        3'd2:    sel_v = (c_v != '0);
        3'd3:    sel_v = (c_v == K_W'(1));
        3'd4:    sel_v = (c_v >= k_q);
        3'd5:    sel_v = c_v[0];
        default: sel_v = 1'b0;
      endcase
      row_sel[x-1] = sel_v;
      row_pop      = row_pop + CNT_W'(sel_v);
    end
  end

  // Job FSM: latch operands, scan rows, drain the popcount stage, then publish the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      y_q         <= COORD_W'(1);
      cen_q       <= '0;
      rad_q       <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      k_q         <= '0;
      s2_valid    <= 1'b0;
      s2_cnt      <= '0;
      acc         <= '0;
      candidate_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef SET_HITMAP_EN
      s2_y        <= '0;
      s2_hits     <= '0;
`endif
    end else begin
      valid_q  <= 1'b0;
      s2_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            cen_q  <= bus.central;
            rad_q  <= bus.radius;
            mask_q <= bus.circ_mask;
            mode_q <= bus.mode;
            k_q    <= bus.k_thresh;
            y_q    <= COORD_W'(1);
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          s2_valid <= 1'b1;
          s2_cnt   <= row_pop;
`ifdef SET_HITMAP_EN
          s2_y     <= y_q;
          s2_hits  <= row_sel;
`endif
          if (s2_valid) acc <= acc + s2_cnt;
          if (y_q == COORD_W'(GRID)) state <= FLUSH;
          else                       y_q   <= y_q + COORD_W'(1);
        end
        FLUSH: begin
          // The last row is still in stage 2, so fold it in while publishing.
          candidate_q <= acc + s2_cnt;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          y_q         <= COORD_W'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.candidate = candidate_q;
`ifdef SET_HITMAP_EN
  assign bus.row_valid = s2_valid;
  assign bus.row_y     = s2_y;
  assign bus.row_hits  = s2_hits;
`endif
endmodule

// File: tb/tb_set_multi_circle.sv
// tb/tb_set_multi_circle.sv - directed self-checking bench for set_multi_circle (optional SET_HITMAP_EN checks)
module tb_set_multi_circle;
  localparam int NUM_C   = 3;
  localparam int COORD_W = 4;
  localparam int GRID    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  set_multi_circle_if #(.NUM_C(NUM_C), .COORD_W(COORD_W), .GRID(GRID)) bus ();

  set_multi_circle #(.NUM_C(NUM_C), .COORD_W(COORD_W), .GRID(GRID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Count one comparison and report it on mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_circ(input int i, input int cx, input int cy, input int r);
    bus.central[i*2*COORD_W +: 2*COORD_W] = {4'(cx), 4'(cy)};
    bus.radius[i*COORD_W +: COORD_W]      = 4'(r);
  endtask

  task automatic clear_circs();
    bus.central = '0;
    bus.radius  = '0;
  endtask

  // Start a job, optionally pulse en in cycle T+pulse_at, and record what the outputs did.
  task automatic job(input int pulse_at, output int v1, output int v2, output logic [6:0] cand,
                     output int busy_bad, output int rows, output logic [7:0] h4);
    logic [23:0] cen_s;
    logic [2:0]  mode_s;
    v1 = 0; v2 = 0; cand = '0; busy_bad = 0; rows = 0; h4 = '0;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    cen_s  = bus.central;
    mode_s = bus.mode;
    bus.central = ~cen_s;
    bus.mode    = ~mode_s;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.valid) begin
        if (v1 == 0) begin
          v1   = k;
          cand = bus.candidate;
        end else if (v2 == 0) begin
          v2 = k;
        end
      end
      if (k <= GRID+1 && bus.busy !== 1'b1) busy_bad++;
      if (k == GRID+2 && bus.busy !== 1'b0) busy_bad++;
`ifdef SET_HITMAP_EN
      if (bus.row_valid) begin
        rows++;
        if (bus.row_y == 4'd4) h4 = bus.row_hits;
      end
`endif
      if (k == pulse_at) begin
        bus.central = cen_s;
        bus.mode    = mode_s;
      end
      bus.en = (k == pulse_at);
    end
    bus.en      = 1'b0;
    bus.central = cen_s;
    bus.mode    = mode_s;
  endtask

  int          v1, v2, bb, rows;
  logic [6:0]  cand;
  logic [7:0]  h4;

  initial begin
    bus.en        = 1'b0;
    bus.central   = '0;
    bus.radius    = '0;
    bus.circ_mask = '0;
    bus.mode      = '0;
    bus.k_thresh  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_cand", 32'(bus.candidate), 0);
    @(negedge clk);
    rst = 1'b1;

    // single circle, mode 0: latency and busy window
    clear_circs();
    set_circ(0, 4, 4, 2);
    bus.circ_mask = 3'b001;
    bus.mode      = 3'd0;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t2_valid_at", 32'(v1), 10);
    check("t2_single", 32'(v2), 0);
    check("t2_cand", 32'(cand), 13);
    check("t2_busy", 32'(bb), 0);

    // two overlapping circles: intersection, union, exactly-one
    clear_circs();
    set_circ(0, 3, 3, 2);
    set_circ(1, 5, 3, 2);
    bus.circ_mask = 3'b011;
    bus.mode = 3'd1;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t3_and", 32'(cand), 5);
    bus.mode = 3'd2;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t3_or", 32'(cand), 21);
    bus.mode = 3'd3;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t3_xor1", 32'(cand), 16);

    // full-grid coverage, thresholds, reserved mode
    clear_circs();
    set_circ(0, 4, 4, 15);
    bus.circ_mask = 3'b001;
    bus.mode = 3'd0;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_full", 32'(cand), 64);
    clear_circs();
    set_circ(0, 4, 4, 2);
    set_circ(1, 1, 1, 0);
    bus.circ_mask = 3'b011;
    bus.mode = 3'd4;
    bus.k_thresh = 2'd2;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_k2", 32'(cand), 0);
    bus.k_thresh = 2'd0;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_k0", 32'(cand), 64);
    bus.mode = 3'd6;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_rsvd", 32'(cand), 0);
    check("t4_rsvd_lat", 32'(v1), 10);
    bus.mode = 3'd5;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_parity", 32'(cand), 14);
    bus.circ_mask = 3'b000;
    bus.mode = 3'd2;
    job(0, v1, v2, cand, bb, rows, h4);
    check("t4_nomask", 32'(cand), 0);

    // en during busy is ignored; en in the valid cycle starts the next job
    clear_circs();
    set_circ(0, 4, 4, 2);
    bus.circ_mask = 3'b001;
    bus.mode = 3'd0;
    job(3, v1, v2, cand, bb, rows, h4);
    check("t5_ign_v1", 32'(v1), 10);
    check("t5_ign_v2", 32'(v2), 0);
    job(10, v1, v2, cand, bb, rows, h4);
    check("t5_b2b_v1", 32'(v1), 10);
    check("t5_b2b_v2", 32'(v2), 20);
    check("t5_b2b_cand", 32'(cand), 13);

    // asynchronous reset while idle
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_valid", 32'(bus.valid), 0);
    check("t1_cand", 32'(bus.candidate), 0);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-scan aborts the job, the following job runs cleanly
    v2 = 0;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_abort_busy", 32'(bus.busy), 0);
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) rst = 1'b1;
      if (bus.valid) v2++;
    end
    check("t6_no_valid", 32'(v2), 0);
    job(0, v1, v2, cand, bb, rows, h4);
    check("t6_valid_at", 32'(v1), 10);
    check("t6_cand", 32'(cand), 13);
`ifdef SET_HITMAP_EN
    check("t6_rows", 32'(rows), 8);
    check("t6_row4", 32'(h4), 32'h3E);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
